// File: rtl/vg_run_ctrl.sv
// Run-state controller for the vector generator: go/reset strobes to start/abort pulses.
// Optional hung-list watchdog enabled by defining VG_WATCHDOG_EN.
module vg_run_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned WDOG_W         = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       vggo,
  input  logic       vgrst,
  input  logic       vg_done,
  output logic       vg_start,
  output logic       vg_abort,
  output logic       halt,
  output logic       pending,
  output logic [7:0] frame_count,
  output logic       timeout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] ABORT  = 2'd3;

  if (TIMEOUT_CYCLES < 1 || (TIMEOUT_CYCLES >> WDOG_W) != 0) begin : g_bad_cfg
    $error("vg_run_ctrl: WDOG_W too narrow for TIMEOUT_CYCLES");
  end

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       pending_nx;
  logic       count_en;
  logic       wd_fire;
  logic       go;
  logic       kill;

  assign go   = vggo  & clk_en;
  assign kill = vgrst & clk_en;

  assign halt     = (state == IDLE);
  assign vg_start = (state == LAUNCH);
  assign vg_abort = (state == ABORT);

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    count_en   = 1'b0;
    case (state)
      IDLE: begin
        if (kill)    state_nx = ABORT;
        else if (go) state_nx = LAUNCH;
      end
      LAUNCH: begin
        if (kill) begin
          state_nx   = ABORT;
          pending_nx = 1'b0;
        end else begin
          state_nx = RUN;
          if (go) pending_nx = 1'b1;
        end
      end
      RUN: begin
        // kill outranks done (no count), done outranks the watchdog
        if (kill) begin
          state_nx   = ABORT;
          pending_nx = 1'b0;
        end else if (vg_done) begin
          count_en = 1'b1;
          if (pending || go) begin
            state_nx   = LAUNCH;
            pending_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else if (wd_fire) begin
          state_nx   = ABORT;
          pending_nx = 1'b0;
        end else if (go) begin
          pending_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      frame_count <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      if (count_en) frame_count <= frame_count + 8'd1;
    end
  end

`ifdef VG_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog;

  // Held at zero outside RUN, so it is clear on every entry to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               wdog <= '0;
    else if (state != RUN) wdog <= '0;
    else                   wdog <= wdog + WDOG_W'(1);
  end

  assign wd_fire = (state == RUN) && (wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) && !vg_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          timeout <= 1'b0;
    else if (wd_fire) timeout <= 1'b1;
    else if (kill)    timeout <= 1'b0;
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_vg_run_ctrl.sv
// Directed self-checking bench for vg_run_ctrl; watchdog section follows VG_WATCHDOG_EN.
module tb_vg_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       vggo;
  logic       vgrst;
  logic       vg_done;
  logic       vg_start;
  logic       vg_abort;
  logic       halt;
  logic       pending;
  logic [7:0] frame_count;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  vg_run_ctrl #(
    .TIMEOUT_CYCLES(100),
    .WDOG_W(18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .vggo(vggo),
    .vgrst(vgrst),
    .vg_done(vg_done),
    .vg_start(vg_start),
    .vg_abort(vg_abort),
    .halt(halt),
    .pending(pending),
    .frame_count(frame_count),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int bad;

  initial begin
    rst = 1'b1; clk_en = 1'b1; vggo = 1'b0; vgrst = 1'b0; vg_done = 1'b0;
    #22;
    rst = 1'b0;
    #1;
    chk("rst_halt", halt, 1);
    chk("rst_start", vg_start, 0);
    chk("rst_abort", vg_abort, 0);
    chk("rst_pending", pending, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_timeout", timeout, 0);

    // Basic go / done
    vggo = 1'b1; step(); vggo = 1'b0;
    chk("go_start", vg_start, 1);
    chk("go_halt", halt, 0);
    step();
    chk("go_start_1wide", vg_start, 0);
    chk("run_halt", halt, 0);
    repeat (48) step();
    vg_done = 1'b1; step(); vg_done = 1'b0;
    chk("done_halt", halt, 1);
    chk("done_fc", frame_count, 1);
    chk("done_start", vg_start, 0);

    // Two gos queued, single relaunch
    vggo = 1'b1; step(); vggo = 1'b0; step();
    vggo = 1'b1; step();
    chk("q_pending1", pending, 1);
    step(); vggo = 1'b0;
    chk("q_pending2", pending, 1);
    vg_done = 1'b1; step(); vg_done = 1'b0;
    chk("q_relaunch", vg_start, 1);
    chk("q_pend_clr", pending, 0);
    chk("q_halt_low", halt, 0);
    chk("q_fc", frame_count, 2);
    step();
    chk("q_run", vg_start, 0);
    vg_done = 1'b1; step(); vg_done = 1'b0;
    chk("q_idle", halt, 1);
    chk("q_fc2", frame_count, 3);
    chk("q_pend_idle", pending, 0);

    // Kill and done together in RUN, with a request pending
    vggo = 1'b1; step(); vggo = 1'b0; step();
    vggo = 1'b1; step(); vggo = 1'b0;
    chk("k_pending", pending, 1);
    vgrst = 1'b1; vg_done = 1'b1; step(); vgrst = 1'b0; vg_done = 1'b0;
    chk("k_abort", vg_abort, 1);
    chk("k_fc", frame_count, 3);
    chk("k_pend", pending, 0);
    chk("k_halt_low", halt, 0);
    step();
    chk("k_abort_1wide", vg_abort, 0);
    chk("k_halt", halt, 1);

    // Strobes ignored without clk_en
    clk_en = 1'b0; vggo = 1'b1; step();
    chk("ce_start", vg_start, 0);
    chk("ce_halt", halt, 1);
    step(); vggo = 1'b0; clk_en = 1'b1;
    chk("ce_halt2", halt, 1);

    // go + kill together in IDLE
    vggo = 1'b1; vgrst = 1'b1; step(); vggo = 1'b0; vgrst = 1'b0;
    chk("gk_abort", vg_abort, 1);
    chk("gk_start", vg_start, 0);
    step();
    chk("gk_halt", halt, 1);
    chk("gk_start2", vg_start, 0);

    // done in IDLE is ignored
    vg_done = 1'b1; step(); vg_done = 1'b0;
    chk("idle_done_fc", frame_count, 3);

    // Wrap: 3 + 252 = 255, then one more -> 0
    for (int i = 0; i < 252; i++) begin
      vggo = 1'b1; step(); vggo = 1'b0; step();
      vg_done = 1'b1; step(); vg_done = 1'b0;
    end
    chk("wrap_255", frame_count, 255);
    vggo = 1'b1; step(); vggo = 1'b0; step();
    vg_done = 1'b1; step(); vg_done = 1'b0;
    chk("wrap_0", frame_count, 0);
    chk("wrap_halt", halt, 1);

    // Hung list
    vggo = 1'b1; step(); vggo = 1'b0;
    step();
    chk("wd_run", halt, 0);
`ifdef VG_WATCHDOG_EN
    bad = 0;
    for (int i = 0; i < 99; i++) begin
      step();
      if (vg_abort !== 1'b0 || halt !== 1'b0) bad++;
    end
    chk("wd_early", bad, 0);
    step();
    chk("wd_abort", vg_abort, 1);
    chk("wd_timeout", timeout, 1);
    chk("wd_fc", frame_count, 0);
    step();
    chk("wd_halt", halt, 1);
    chk("wd_sticky", timeout, 1);
    vgrst = 1'b1; step(); vgrst = 1'b0;
    chk("wd_clr", timeout, 0);
    step();
`else
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (halt !== 1'b0 || vg_abort !== 1'b0 || timeout !== 1'b0) bad++;
    end
    chk("nowd_persist", bad, 0);
    chk("nowd_timeout", timeout, 0);
    vgrst = 1'b1; step(); vgrst = 1'b0;
    chk("nowd_abort", vg_abort, 1);
    step();
`endif
    chk("end_halt", halt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vg_run_ctrl.md
# vg_run_ctrl

Run-state controller between the CPU address decoder and the vector generator engine. It turns the decoder's `vggo` and `vgrst` write strobes into single-cycle start and abort pulses for the engine. It tracks the engine's busy/halted state and drives the `halt` status bit that the decoder returns on reads of 0x0800. It also queues one pending restart, counts completed display lists, and optionally aborts a hung list with a watchdog.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 200000: watchdog limit, in `clk` cycles spent in RUN.
- `WDOG_W`, default 18: watchdog counter width. Must satisfy 2^WDOG_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1: the single system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `clk_en`  in  1: CPU clock enable. Strobes are sampled only when `clk_en`=1.
- `vggo`  in  1: decoder strobe for a write to 0x1200 (VG go).
- `vgrst`  in  1: decoder strobe for a write to 0x1600 (VG reset).
- `vg_done`  in  1: engine pulse on executing a HALT opcode. Sampled every `clk`.
- `vg_start`  out  1: one-cycle pulse; the engine begins fetching at vector RAM base.
- `vg_abort`  out  1: one-cycle pulse; the engine returns to idle immediately.
- `halt`  out  1: 1 while the engine is idle. Routed to decoder status bit 6.
- `pending`  out  1: a go request is queued behind the current list.
- `frame_count`  out  8: number of completed lists, modulo 256.
- `timeout`  out  1: sticky flag, set when the watchdog fires.

## Operation
- FSM states: IDLE, LAUNCH, RUN, ABORT. Reset state is IDLE.
- Reset values: `halt`=1; `vg_start`=0; `vg_abort`=0; `pending`=0; `frame_count`=0; `timeout`=0; watchdog counter=0.
- Accepted strobes: `go` = `vggo`&`clk_en`; `kill` = `vgrst`&`clk_en`. Strobes are level-qualified, not edge-detected: each CPU write cycle yields exactly one `clk_en` sample.
- `halt` = (state==IDLE). `vg_start` = (state==LAUNCH). `vg_abort` = (state==ABORT). All outputs are registered or decoded from state; none is combinational from an input.
- IDLE:
  - `kill` → ABORT.
  - else `go` → LAUNCH.
  - `vg_done` is ignored.
- LAUNCH: unconditionally → RUN, except `kill` → ABORT. A `go` arriving in LAUNCH sets `pending`.
- RUN:
  - Priority order: `kill` > `vg_done` > watchdog > `go`.
  - `kill` → ABORT and clears `pending`. `frame_count` is not incremented, even if `vg_done` arrives in the same cycle.
  - `vg_done` → `frame_count`+1. Then if `pending`, or `go` in the same cycle: → LAUNCH and clear `pending`. Otherwise → IDLE.
  - `go` alone → set `pending`. A second `go` while already pending is dropped; there is only one queue slot.
- ABORT: → IDLE after one cycle. `go` in ABORT is dropped. `kill` in ABORT has no additional effect.
- `frame_count` wraps from 255 to 0. It is not cleared by `kill`.
- `timeout` is cleared by `kill`, except when the watchdog fires in the same cycle; see Configuration.

## Timing
- A `go` sampled at edge k gives: `vg_start` high and `halt` low during cycle k+1; RUN from edge k+2.
- A `vg_done` sampled at edge m in RUN gives: `halt` high from cycle m+1. With a pending request, `vg_start` instead pulses in cycle m+1 and `halt` stays low.
- A `kill` sampled at edge k gives: `vg_abort` high in cycle k+1, `halt` high from cycle k+2.
- `vg_start` and `vg_abort` are never asserted together and are never wider than one `clk` cycle.
- Asynchronous `rst` mid-list: all outputs go to their reset values immediately, with no `vg_abort` pulse. The engine shares `rst`.

## Configuration
- `VG_WATCHDOG_EN` defined:
  - The watchdog counter clears on entry to RUN and increments every `clk` in RUN.
  - When the counter equals TIMEOUT_CYCLES-1 with no `vg_done` that cycle: → ABORT, set `timeout`, clear `pending`. `frame_count` is unchanged.
  - If the watchdog fires in the same cycle as `kill`, `timeout` is still set.
- `VG_WATCHDOG_EN` undefined:
  - No counter is instantiated. `timeout` is tied to 0.
  - RUN waits indefinitely for `vg_done` or `kill`.

## Test plan
- Reset, then check outputs: `halt`=1, `frame_count`=0. Pulse `vggo` with `clk_en` → `vg_start` is exactly 1 cycle wide and `halt`=0. `vg_done` 50 cycles later → `halt`=1 and `frame_count`=1.
- In RUN, two `go` strobes, then `vg_done` → one immediate relaunch (`vg_start` in the next cycle) with `pending` cleared. Second `vg_done` → IDLE, `frame_count`=2.
- In RUN, `vgrst` and `vg_done` in the same cycle → `vg_abort` pulse, `frame_count` unchanged, `pending`=0, `halt`=1 two cycles later.
- `vggo` with `clk_en`=0 → no state change. `vggo`+`vgrst` together in IDLE → `vg_abort` only, no `vg_start`.
- 256 complete go/done cycles → `frame_count` wraps to 0.
- With `VG_WATCHDOG_EN` and TIMEOUT_CYCLES=100: after `go`, hold `vg_done` low → `vg_abort` exactly 100 cycles after entering RUN, `timeout`=1. Next `vgrst` → `timeout`=0. Without the macro, the same stimulus → RUN persists for 10000 cycles and `timeout`=0.
